alu_rr_arbiter: RTL and testbench
=================================

// Module: alu_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one alu instance among N_REQ requesters. Each requester has a
//  valid/ready request channel (a, b, op) and a valid/ready response channel (result, flags).
//  The block keeps at most one operation in flight, so the ALU operand latch is never
//  overwritten while a result is pending. It routes each result back to the requester that issued it.
// PARAMETERS
//  WIDTH  32  operand/result width; must match the alu WIDTH
//  N_REQ  4   number of requesters, 2..16; ID_W = $clog2(N_REQ)
// PORTS
//  clk            in   1            single clock, rising edge
//  rst            in   1            asynchronous, active-high reset
//  req_valid      in   N_REQ        per-requester request valid
//  req_ready      out  N_REQ        per-requester accept; one-hot or zero
//  req_a          in   N_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//  req_b          in   N_REQ*WIDTH  operand B, same packing as req_a
//  req_op         in   N_REQ*3      alu_pkg::alu_op_e per requester, at [i*3 +: 3]
//  rsp_valid      out  N_REQ        one-hot response valid
//  rsp_ready      in   N_REQ        per-requester response accept
//  rsp_result     out  WIDTH        shared response data
//  rsp_flags      out  4            {zero,neg,ovf,carry} of the response
//  alu_req_valid  out  1            to alu req_valid
//  alu_req_ready  in   1            from alu req_ready
//  alu_a/alu_b    out  WIDTH        to alu a/b
//  alu_op         out  3            to alu op
//  alu_rsp_valid  in   1            from alu rsp_valid
//  alu_result     in   WIDTH        from alu result
//  alu_flags      in   4            {zero,neg,ovf,carry} from alu
//  busy           out  1            op in flight or response held
//  err_spurious   out  1            sticky: alu_rsp_valid seen with no op in flight
// BEHAVIOUR
//  Reset: all outputs 0 (req_ready, rsp_valid, alu_req_valid, alu_a/b/op, rsp_result, rsp_flags,
//   busy, err_spurious); RR pointer=0; FSM=IDLE; held response dropped. Reset mid-op abandons
//   the op; no response is delivered for it.
//  State: FSM {IDLE, WAIT, CAPT}, rsp_full flag, owner id (ID_W bits), rr_ptr.
//  can_issue = (FSM==IDLE) && (!rsp_full || rsp_valid&rsp_ready for the held owner).
//  Grant (combinational): first i with req_valid[i] set, searching from rr_ptr upward and
//   wrapping at N_REQ-1 -> 0. alu_req_valid = can_issue && |req_valid.
//   alu_a/b/op = the granted requester's fields, 0 when not valid.
//   req_ready[i] = granted[i] && can_issue && alu_req_ready.
//  Issue fires when alu_req_valid && alu_req_ready. On issue: owner<=i; rr_ptr<=(i+1)%N_REQ;
//   FSM IDLE->WAIT. If alu_req_ready=0, nothing changes and the grant may move next cycle.
//  WAIT->CAPT unconditionally. ALU latency is 2 cycles: rsp_valid arrives in CAPT.
//  In CAPT with alu_rsp_valid=1: rsp_result<=alu_result; rsp_flags<=alu_flags; rsp_full<=1;
//   FSM->IDLE. Without alu_rsp_valid: stay in CAPT until it arrives; no timeout.
//  rsp_valid[owner] = rsp_full. The held response stays stable until rsp_ready[owner]=1;
//   rsp_ready of other requesters is ignored. Pop clears rsp_full.
//   Pop and issue may occur in the same cycle.
//  Minimum issue spacing: 3 cycles (issue C0, capture end of C2, rsp_valid and next issue in C3).
//  alu_rsp_valid in IDLE or WAIT: ignored; set err_spurious (cleared only by rst).
//  busy = (FSM!=IDLE) || rsp_full.
//  The block performs no arithmetic; flags and result pass through bit-exact.
//  req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready,
//   and must hold the request stable until accepted.
// TESTING
//  T1 req0 ADD a=5 b=7, rsp_ready=1 -> alu_req at C0; rsp_valid=4'b0001, result 12,
//     flags 4'b0000 at C3.
//  T2 req0..3 all valid, rsp_ready all 1 -> grant order 0,1,2,3 at C0,C3,C6,C9.
//     Each rsp_valid is one-hot to the issuer.
//  T3 req0 and req2 valid continuously -> grants alternate 0,2,0,2; req1/3 ready never set.
//  T4 req1 SUB 0-1, rsp_ready[1]=0 for 5 cycles -> result 0xFFFFFFFF, flags 4'b0100,
//     held stable; no issue until pop.
//  T5 alu_rsp_valid pulsed in IDLE -> err_spurious=1 and stays 1; no rsp_valid.
//  T6 rst asserted in WAIT -> all outputs 0 asynchronously; after release, first grant is req0.

Source files
------------

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU among N_REQ requesters with a single operation in flight;
// each result is held and routed back to the requester that issued it.
module alu_rr_arbiter #(
    parameter int WIDTH = 32,
    parameter int N_REQ = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ*3-1:0]     req_op,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]       rsp_result,
    output logic [3:0]             rsp_flags,
    output logic                   alu_req_valid,
    input  logic                   alu_req_ready,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic [2:0]             alu_op,
    input  logic                   alu_rsp_valid,
    input  logic [WIDTH-1:0]       alu_result,
    input  logic [3:0]             alu_flags,
    output logic                   busy,
    output logic                   err_spurious
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // state | meaning
    // IDLE  | may issue a new op; a response may still be held
    // WAIT  | op accepted by the ALU, first latency cycle
    // CAPT  | waiting for alu_rsp_valid to capture the result
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, CAPT = 2'd2} state_t;

    state_t          state;
    logic            rsp_full;
    logic [ID_W-1:0] owner;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant_id;
    logic            grant_found;
    logic            held_pop;
    logic            can_issue;
    logic            issue;

    // Search from rr_ptr upward with wrap; compare against constants to avoid variable indexing.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!grant_found && req_valid[i] && ((int'(rr_ptr) + k) % N_REQ == i)) begin
                    grant_found = 1'b1;
                    grant_id    = ID_W'(i);
                end
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_valid[i] = rsp_full && (owner == ID_W'(i));
        end
        held_pop      = |(rsp_valid & rsp_ready);
        can_issue     = !rst && (state == IDLE) && (!rsp_full || held_pop);
        alu_req_valid = can_issue && grant_found;
        issue         = alu_req_valid && alu_req_ready;
        req_ready     = '0;
        alu_a         = '0;
        alu_b         = '0;
        alu_op        = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (alu_req_valid && (grant_id == ID_W'(i))) begin
                alu_a        = req_a[i*WIDTH +: WIDTH];
                alu_b        = req_b[i*WIDTH +: WIDTH];
                alu_op       = req_op[i*3 +: 3];
                req_ready[i] = alu_req_ready;
            end
        end
        busy = (state != IDLE) || rsp_full;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rsp_full     <= 1'b0;
            owner        <= '0;
            rr_ptr       <= '0;
            rsp_result   <= '0;
            rsp_flags    <= '0;
            err_spurious <= 1'b0;
        end else begin
            if (held_pop) begin
                rsp_full <= 1'b0;
            end
            if (alu_rsp_valid && (state != CAPT)) begin
                err_spurious <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (issue) begin
                        owner  <= grant_id;
                        rr_ptr <= (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + 1'b1;
                        state  <= WAIT;
                    end
                end
                WAIT: state <= CAPT;
                CAPT: begin
                    if (alu_rsp_valid) begin
                        rsp_result <= alu_result;
                        rsp_flags  <= alu_flags;
                        rsp_full   <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Scoreboard bench for alu_rr_arbiter: a behavioural ALU with 2+ cycle latency, a queue-based
// reference of grant order and response routing, directed scenarios and a randomized phase.
module tb_alu_rr_arbiter;
    localparam int WIDTH = 32;
    localparam int N = 4;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*WIDTH-1:0] req_a, req_b;
    logic [N*3-1:0]   req_op;
    logic [WIDTH-1:0] rsp_result, alu_a, alu_b, alu_result;
    logic [3:0]       rsp_flags, alu_flags;
    logic [2:0]       alu_op;
    logic             alu_req_valid, alu_req_ready, alu_rsp_valid, busy, err_spurious;
    logic             alu_rsp_model, spur;

    assign alu_rsp_valid = alu_rsp_model | spur;

    alu_rr_arbiter #(.WIDTH(WIDTH), .N_REQ(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .alu_req_valid(alu_req_valid), .alu_req_ready(alu_req_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_rsp_valid(alu_rsp_valid), .alu_result(alu_result), .alu_flags(alu_flags),
        .busy(busy), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic [3:0]  flg;
        int          cyc;
        int          due;
    } exp_t;

    exp_t   sb[$];
    int     grant_log[$];
    int     fire_log[$];
    int     ready_cnt[N];
    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;
    int     model_ptr = 0;
    int     rst_count = 0;
    int     alu_delay = 0;
    logic [N-1:0] accepted = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference ALU: returns {zero,neg,ovf,carry, result}.
    function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        logic [32:0] w;
        logic        ovf;
        ovf = 1'b0;
        case (op)
            3'd0: begin w = {1'b0, a} + {1'b0, b};          ovf = (a[31] == b[31]) && (w[31] != a[31]); end
            3'd1: begin w = {1'b0, a} + {1'b0, ~b} + 33'd1; ovf = (a[31] != b[31]) && (w[31] != a[31]); end
            3'd2: w = {1'b0, a & b};
            3'd3: w = {1'b0, a | b};
            3'd4: w = {1'b0, a ^ b};
            default: w = {1'b0, a};
        endcase
        return {(w[31:0] == 32'd0), w[31], ovf, w[32], w[31:0]};
    endfunction

    always @(posedge rst) rst_count <= rst_count + 1;

    initial begin : alu_model
        logic [35:0] r;
        int gen;
        int d;
        alu_rsp_model = 1'b0;
        alu_result = '0;
        alu_flags = '0;
        forever begin
            @(negedge clk);
            if (!rst && alu_req_valid && alu_req_ready) begin
                r = alu_ref(alu_a, alu_b, alu_op);
                gen = rst_count;
                d = alu_delay;
                repeat (2 + d) @(posedge clk);
                #1;
                if (gen == rst_count && !rst) begin
                    alu_rsp_model = 1'b1;
                    alu_result = r[31:0];
                    alu_flags = r[35:32];
                    @(posedge clk);
                    #1;
                    alu_rsp_model = 1'b0;
                    alu_result = $urandom;
                    alu_flags = 4'($urandom);
                end
            end
        end
    end

    initial begin : monitor
        logic presenting, popping, exp_can, prev_hold;
        logic [N-1:0] prev_valid, onehot;
        logic [31:0] prev_res;
        logic [3:0]  prev_flg;
        logic [35:0] r;
        int winner, idx;
        exp_t e;
        prev_hold = 1'b0;
        prev_valid = '0;
        prev_res = '0;
        prev_flg = '0;
        forever begin
            @(negedge clk);
            cyc++;
            accepted = '0;
            if (rst) begin
                sb.delete();
                model_ptr = 0;
                prev_hold = 1'b0;
            end else begin
                presenting = (rsp_valid != '0);
                popping = presenting && ((rsp_valid & rsp_ready) != '0);
                exp_can = (sb.size() == 0) || (sb.size() == 1 && popping);
                check("alu_req_valid", alu_req_valid, exp_can && (req_valid != '0));
                if (presenting) begin
                    check("rsp_onehot", $onehot(rsp_valid), 1);
                    if (prev_hold) begin
                        check("rsp_stable_valid", rsp_valid, prev_valid);
                        check("rsp_stable_result", rsp_result, prev_res);
                        check("rsp_stable_flags", rsp_flags, prev_flg);
                    end else if (sb.size() == 0) begin
                        check("rsp_unexpected", rsp_valid, 0);
                    end else begin
                        e = sb[0];
                        onehot = '0;
                        onehot[e.id] = 1'b1;
                        check("rsp_owner", rsp_valid, onehot);
                        check("rsp_result", rsp_result, e.res);
                        check("rsp_flags", rsp_flags, e.flg);
                        check("rsp_latency", cyc - e.cyc, e.due);
                    end
                    if (popping && sb.size() != 0) void'(sb.pop_front());
                    prev_hold = !popping;
                    prev_valid = rsp_valid;
                    prev_res = rsp_result;
                    prev_flg = rsp_flags;
                end else begin
                    if (prev_hold) check("rsp_dropped", rsp_valid, prev_valid);
                    prev_hold = 1'b0;
                end
                if (alu_req_valid && alu_req_ready) begin
                    winner = -1;
                    for (int k = 0; k < N; k++) begin
                        idx = (model_ptr + k) % N;
                        if (winner < 0 && req_valid[idx]) winner = idx;
                    end
                    if (winner < 0) begin
                        check("issue_without_request", alu_req_valid, 0);
                    end else begin
                        onehot = '0;
                        onehot[winner] = 1'b1;
                        check("grant", req_ready, onehot);
                        check("alu_a", alu_a, req_a[winner*WIDTH +: WIDTH]);
                        check("alu_b", alu_b, req_b[winner*WIDTH +: WIDTH]);
                        check("alu_op", alu_op, req_op[winner*3 +: 3]);
                        r = alu_ref(req_a[winner*WIDTH +: WIDTH], req_b[winner*WIDTH +: WIDTH],
                                    req_op[winner*3 +: 3]);
                        sb.push_back('{id: winner, res: r[31:0], flg: r[35:32], cyc: cyc, due: 3 + alu_delay});
                        grant_log.push_back(winner);
                        fire_log.push_back(cyc);
                        model_ptr = (winner + 1) % N;
                        accepted[winner] = 1'b1;
                    end
                end else begin
                    check("req_ready_idle", req_ready, 0);
                end
                for (int i = 0; i < N; i++) if (req_ready[i]) ready_cnt[i]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        req_valid = req_valid & ~accepted;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        req_op[i*3 +: 3] = op;
        req_valid[i] = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || req_valid != '0) && n < 200) begin
            tick();
            n++;
        end
        check(name, {busy, (req_valid != '0)}, 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_alu_req_valid"}, alu_req_valid, 0);
        check({tag, "_alu_a"}, alu_a, 0);
        check({tag, "_alu_b"}, alu_b, 0);
        check({tag, "_alu_op"}, alu_op, 0);
        check({tag, "_rsp_result"}, rsp_result, 0);
        check({tag, "_rsp_flags"}, rsp_flags, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err_spurious, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #1_000_000;
        failures++;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : stimulus
        int base, r1, r3, n;
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        req_op = '0;
        rsp_ready = '1;
        alu_req_ready = 1'b1;
        spur = 1'b0;
        for (int i = 0; i < N; i++) ready_cnt[i] = 0;
        #3;
        check_zero_outputs("reset");
        repeat (2) tick();
        rst = 1'b0;

        // T1: single ADD, response three cycles after issue
        set_req(0, 32'd5, 32'd7, OP_ADD);
        #1;
        check("t1_alu_req_valid", alu_req_valid, 1);
        check("t1_req_ready", req_ready, 4'b0001);
        check("t1_alu_a", alu_a, 5);
        check("t1_alu_b", alu_b, 7);
        repeat (3) tick();
        #1;
        check("t1_rsp_valid", rsp_valid, 4'b0001);
        check("t1_rsp_result", rsp_result, 12);
        check("t1_rsp_flags", rsp_flags, 4'b0000);
        wait_idle("t1_idle");

        // T2: all requesters valid after reset -> 0,1,2,3 every 3 cycles
        do_reset();
        base = grant_log.size();
        for (int i = 0; i < N; i++) set_req(i, 32'(i * 10), 32'(i + 1), OP_ADD);
        wait_idle("t2_idle");
        check("t2_count", grant_log.size() - base, 4);
        if (grant_log.size() - base == 4) begin
            for (int k = 0; k < 4; k++) begin
                check("t2_order", grant_log[base + k], k);
                if (k > 0) check("t2_spacing", fire_log[base + k] - fire_log[base + k - 1], 3);
            end
        end

        // T3: req0 and req2 continuously valid -> alternate, req1/3 never readied
        base = grant_log.size();
        r1 = ready_cnt[1];
        r3 = ready_cnt[3];
        for (int c = 0; c < 20; c++) begin
            if (!req_valid[0]) set_req(0, $urandom, $urandom, 3'($urandom_range(0, 4)));
            if (!req_valid[2]) set_req(2, $urandom, $urandom, 3'($urandom_range(0, 4)));
            tick();
        end
        wait_idle("t3_idle");
        check("t3_enough_grants", (grant_log.size() - base) >= 6, 1);
        if (grant_log.size() - base >= 6) begin
            for (int k = 0; k < 6; k++) check("t3_alternate", grant_log[base + k], (k % 2) * 2);
        end
        check("t3_req1_never_ready", ready_cnt[1] - r1, 0);
        check("t3_req3_never_ready", ready_cnt[3] - r3, 0);

        // T4: held response, other rsp_ready ignored, pop and issue in the same cycle
        rsp_ready = 4'b1101;
        set_req(1, 32'd0, 32'd1, OP_SUB);
        n = 0;
        while (rsp_valid == '0 && n < 20) begin
            tick();
            n++;
        end
        check("t4_rsp_arrived", (rsp_valid != '0), 1);
        set_req(0, 32'd3, 32'd4, OP_ADD);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("t4_rsp_valid", rsp_valid, 4'b0010);
            check("t4_result", rsp_result, 32'hFFFF_FFFF);
            check("t4_flags", rsp_flags, 4'b0100);
            check("t4_no_issue", alu_req_valid, 0);
            tick();
        end
        rsp_ready = 4'b1111;
        #1;
        check("t4_issue_on_pop", alu_req_valid, 1);
        check("t4_pop_grant", req_ready, 4'b0001);
        tick();
        wait_idle("t4_idle");

        // T5: spurious ALU response in IDLE
        check("t5_err_before", err_spurious, 0);
        spur = 1'b1;
        tick();
        spur = 1'b0;
        #1;
        check("t5_err_set", err_spurious, 1);
        check("t5_no_rsp", rsp_valid, 0);
        check("t5_not_busy", busy, 0);
        repeat (3) tick();
        check("t5_err_sticky", err_spurious, 1);

        // T6: reset while in WAIT abandons the op; grant restarts at req0
        set_req(0, 32'd9, 32'd9, OP_ADD);
        tick();
        #1;
        check("t6_busy_in_wait", busy, 1);
        set_req(1, 32'd1, 32'd1, OP_ADD);
        rst = 1'b1;
        #1;
        check_zero_outputs("t6");
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 32'(100 + i), 32'(i), OP_SUB);
        #1;
        check("t6_first_grant", req_ready, 4'b0001);
        wait_idle("t6_idle");

        // Randomized traffic with backpressure on both sides and variable ALU latency
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 5) == 0)
                        set_req(i, 32'h8000_0000, 32'($urandom_range(0, 1)) ? 32'h8000_0000 : 32'h7FFF_FFFF,
                                3'($urandom_range(0, 1)));
                    else
                        set_req(i, $urandom, $urandom, 3'($urandom_range(0, 7)));
                end
            end
            rsp_ready = 4'($urandom);
            alu_req_ready = ($urandom_range(0, 3) != 0);
            alu_delay = $urandom_range(0, 2);
            tick();
        end
        rsp_ready = '1;
        alu_req_ready = 1'b1;
        alu_delay = 0;
        wait_idle("drain_idle");
        repeat (2) tick();
        check("drain_scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
